if_id_pipe: RTL and testbench

//   Parametrised IF->ID pipeline register with valid/ready handshake, flush and optional
//   one-entry skid buffer. Sits between fetch and decode. Decouples fetch stalls from

---
 rtl/if_id_pipe_pkg.sv | 15 +
 rtl/pipe_skid_buf.sv | 42 ++++
 rtl/if_id_pipe.sv | 135 +++++++++++++
 tb/tb_if_id_pipe.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/if_id_pipe_pkg.sv
// Shared widths, NOP encoding and FSM state type for the IF->ID pipeline register.
package if_id_pipe_pkg;

    localparam int          DEF_INST_W   = 32;
    localparam int          DEF_ADDR_W   = 32;
    localparam int          DEF_CNT_W    = 16;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic {valid, data} holding register with load and clear; clear wins over load.
module pipe_skid_buf #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/if_id_pipe.sv
// IF->ID pipeline register: valid/ready handshake, flush, optional one-entry skid
// buffer with a registered if_ready, and a saturating decode-starvation counter.
module if_id_pipe
    import if_id_pipe_pkg::*;
#(
    parameter int                INST_W   = DEF_INST_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter bit                SKID_EN  = 1'b1,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(DEF_NOP_INST),
    parameter int                CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [INST_W-1:0] if_inst,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [INST_W-1:0] id_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int PW = ADDR_W + INST_W;

    pipe_state_e state_q, state_d;
    logic        ready_q, ready_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;

    logic          main_load, main_clear, skid_load, skid_clear;
    logic [PW-1:0] main_in, main_data, skid_data;
    logic          main_valid, skid_valid;
    logic          in_fire, out_fire;

    assign in_fire  = if_valid & if_ready;
    assign out_fire = main_valid & id_ready;

    always_comb begin
        state_d    = state_q;
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        main_in    = {if_pc, if_inst};
        if (flush) begin
            state_d    = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d   = ST_FULL;
                        main_load = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire && SKID_EN) begin
                        state_d   = ST_SKID;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_d    = ST_EMPTY;
                        main_clear = 1'b1;
                    end
                end
                ST_SKID: begin
                    // Skid entry slides into the main register as decode drains it.
                    if (out_fire && skid_valid) begin
                        state_d    = ST_FULL;
                        main_in    = skid_data;
                        main_load  = 1'b1;
                        skid_clear = 1'b1;
                    end
                end
                default: begin
                    state_d    = ST_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        ready_d  = (state_d != ST_SKID);
        bubble_d = bubble_q;
        if (id_ready && !main_valid && !flush && (bubble_q != '1)) begin
            bubble_d = bubble_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            ready_q  <= 1'b1;
            bubble_q <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            bubble_q <= bubble_d;
        end
    end

    pipe_skid_buf #(.W(PW)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_in),
        .valid (main_valid),
        .data  (main_data)
    );

    pipe_skid_buf #(.W(PW)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .d     ({if_pc, if_inst}),
        .valid (skid_valid),
        .data  (skid_data)
    );

    // Without the skid entry, ready must look through to decode in the same cycle.
    assign if_ready   = SKID_EN ? ready_q : (!main_valid || id_ready);
    assign id_valid   = main_valid;
    assign id_inst    = main_valid ? main_data[INST_W-1:0] : NOP_INST;
    assign id_pc      = main_valid ? main_data[PW-1:INST_W] : '0;
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_if_id_pipe.sv
// Drives three pipe variants (skid/16-bit, skid/4-bit counter, no-skid) from shared
// inputs and compares each against a small two-entry FIFO model.
module tb_if_id_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, if_valid, id_ready;
    logic [31:0] if_inst, if_pc;

    logic        if_ready_o [3];
    logic        id_valid_o [3];
    logic [31:0] id_inst_o  [3];
    logic [31:0] id_pc_o    [3];
    logic [15:0] bub0, bub2;
    logic [3:0]  bub1;
    logic [15:0] bub_obs    [3];

    int nAsserts = 0;
    int nFails   = 0;

    int          m_cnt  [3];
    logic [31:0] m_pc   [3][2];
    logic [31:0] m_in   [3][2];
    logic        m_rdy  [3];
    int          m_bub  [3];
    int          m_bmax [3];
    bit          m_skid [3];

    always #5 clk = ~clk;

    assign bub_obs[0] = bub0;
    assign bub_obs[1] = {12'b0, bub1};
    assign bub_obs[2] = bub2;

    if_id_pipe #(.SKID_EN(1'b1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_ready(if_ready_o[0]),
        .if_inst(if_inst), .if_pc(if_pc), .id_valid(id_valid_o[0]), .id_ready(id_ready),
        .id_inst(id_inst_o[0]), .id_pc(id_pc_o[0]), .bubble_cnt(bub0)
    );

    if_id_pipe #(.SKID_EN(1'b1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_ready(if_ready_o[1]),
        .if_inst(if_inst), .if_pc(if_pc), .id_valid(id_valid_o[1]), .id_ready(id_ready),
        .id_inst(id_inst_o[1]), .id_pc(id_pc_o[1]), .bubble_cnt(bub1)
    );

    if_id_pipe #(.SKID_EN(1'b0), .CNT_W(16)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_ready(if_ready_o[2]),
        .if_inst(if_inst), .if_pc(if_pc), .id_valid(id_valid_o[2]), .id_ready(id_ready),
        .id_inst(id_inst_o[2]), .id_pc(id_pc_o[2]), .bubble_cnt(bub2)
    );

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        for (int i = 0; i < 3; i++) begin
            logic        expRdy;
            logic        expVal;
            expVal = (m_cnt[i] > 0);
            expRdy = m_skid[i] ? m_rdy[i] : ((m_cnt[i] == 0) || id_ready);
            checkEq($sformatf("id_valid[%0d]", i), 32'(id_valid_o[i]), 32'(expVal));
            checkEq($sformatf("id_pc[%0d]", i), id_pc_o[i], expVal ? m_pc[i][0] : 32'h0);
            checkEq($sformatf("id_inst[%0d]", i), id_inst_o[i], expVal ? m_in[i][0] : 32'h0);
            checkEq($sformatf("if_ready[%0d]", i), 32'(if_ready_o[i]), 32'(expRdy));
            checkEq($sformatf("bubble_cnt[%0d]", i), 32'(bub_obs[i]), 32'(m_bub[i]));
        end
    endtask

    // Pipe viewed as a FIFO of capacity 2 (skid) or 1 (no skid).
    task automatic modelStep();
        for (int i = 0; i < 3; i++) begin
            logic rdy, inF, outF;
            rdy  = m_skid[i] ? m_rdy[i] : ((m_cnt[i] == 0) || id_ready);
            inF  = if_valid && rdy;
            outF = (m_cnt[i] > 0) && id_ready;
            if (rst) begin
                m_cnt[i] = 0;
                m_rdy[i] = 1'b1;
                m_bub[i] = 0;
            end else begin
                if (id_ready && (m_cnt[i] == 0) && !flush && (m_bub[i] < m_bmax[i])) m_bub[i]++;
                if (flush) begin
                    m_cnt[i] = 0;
                end else begin
                    if (outF) begin
                        m_pc[i][0] = m_pc[i][1];
                        m_in[i][0] = m_in[i][1];
                        m_cnt[i]--;
                    end
                    if (inF) begin
                        m_pc[i][m_cnt[i]] = if_pc;
                        m_in[i][m_cnt[i]] = if_inst;
                        m_cnt[i]++;
                    end
                end
                m_rdy[i] = (m_cnt[i] < 2);
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic iv, input logic ir,
                                 input logic [31:0] pc);
        @(negedge clk);
        rst      = r;
        flush    = f;
        if_valid = iv;
        id_ready = ir;
        if_pc    = pc;
        if_inst  = $urandom;
        #1;
        checkOutput();
        modelStep();
    endtask

    initial begin
        m_skid[0] = 1'b1; m_skid[1] = 1'b1; m_skid[2] = 1'b0;
        m_bmax[0] = 65535; m_bmax[1] = 15; m_bmax[2] = 65535;
        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        if_inst = 32'h0; if_pc = 32'h0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_rdy[i] = 1'b1; m_bub[i] = 0;
            m_pc[i][0] = 0; m_pc[i][1] = 0; m_in[i][0] = 0; m_in[i][1] = 0;
        end

        $display("[TB] streaming with decode always ready");
        applyStimulus(0, 0, 1, 1, 32'h0);
        applyStimulus(0, 0, 1, 1, 32'h4);
        checkEq("stream_first_pc", id_pc_o[0], 32'h0);
        applyStimulus(0, 0, 1, 1, 32'h8);
        checkEq("stream_second_pc", id_pc_o[0], 32'h4);
        applyStimulus(0, 0, 0, 1, 32'h0);
        checkEq("stream_third_pc", id_pc_o[0], 32'h8);
        applyStimulus(1, 0, 0, 0, 32'h0);

        $display("[TB] back-pressure into skid");
        applyStimulus(0, 0, 1, 1, 32'h4);
        applyStimulus(0, 0, 1, 0, 32'h8);
        applyStimulus(0, 0, 1, 0, 32'hC);
        checkEq("bp_frozen_pc", id_pc_o[0], 32'h4);
        checkEq("bp_ready_low", 32'(if_ready_o[0]), 32'h0);
        applyStimulus(0, 0, 0, 1, 32'h0);
        applyStimulus(0, 0, 0, 1, 32'h0);
        checkEq("bp_release_pc", id_pc_o[0], 32'h8);

        $display("[TB] flush while skid is occupied");
        applyStimulus(0, 0, 1, 0, 32'h20);
        applyStimulus(0, 0, 1, 0, 32'h24);
        applyStimulus(0, 1, 1, 0, 32'h10);
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkEq("flush_valid", 32'(id_valid_o[0]), 32'h0);
        checkEq("flush_nop", id_inst_o[0], 32'h0);
        checkEq("flush_ready", 32'(if_ready_o[0]), 32'h1);

        $display("[TB] reset mid-stream and bubble counting");
        applyStimulus(0, 0, 1, 1, 32'h30);
        applyStimulus(0, 0, 1, 0, 32'h34);
        applyStimulus(1, 0, 1, 0, 32'h38);
        applyStimulus(0, 0, 0, 1, 32'h0);
        checkEq("rst_valid", 32'(id_valid_o[0]), 32'h0);
        checkEq("rst_pc", id_pc_o[0], 32'h0);
        checkEq("rst_bubble", 32'(bub0), 32'h0);
        checkEq("rst_ready", 32'(if_ready_o[0]), 32'h1);
        repeat (4) applyStimulus(0, 0, 0, 1, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkEq("bubble_five", 32'(bub0), 32'd5);
        repeat (20) applyStimulus(0, 0, 0, 1, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkEq("bubble_sat4", 32'(bub1), 32'd15);
        checkEq("bubble_wide", 32'(bub0), 32'd25);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(63) == 0, $urandom_range(15) == 0,
                          $urandom_range(3) != 0, $urandom_range(2) != 0,
                          $urandom & 32'hFFFF_FFFC);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
